// File: rtl/crc_frame_seq_pkg.sv
// rtl/crc_frame_seq_pkg.sv - shared types and constants for the CRC frame sequencer
package crc_frame_pkg;

  localparam int BYTE_W    = 8;
  localparam int CRC_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    DATA   = 3'd2,
    CRC_HI = 3'd3,
    CRC_LO = 3'd4,
    DROP   = 3'd5
  } state_t;

endpackage

// File: rtl/crc_frame_seq_if.sv
// rtl/crc_frame_seq_if.sv - payload in, framed bytes out and CRC stage control signals
interface crc_frame_seq_if;
  import crc_frame_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [BYTE_W-1:0] crc_d;
  logic              crc_calc;
  logic              crc_init;
  logic              crc_d_valid;
  logic [BYTE_W-1:0] crc_byte;

  modport slave (
    input  in_data, in_valid, in_last, out_ready, crc_byte,
    output in_ready, out_data, out_valid, out_last,
           crc_d, crc_calc, crc_init, crc_d_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready, crc_byte,
    input  in_ready, out_data, out_valid, out_last,
           crc_d, crc_calc, crc_init, crc_d_valid
  );

endinterface

// File: rtl/crc_frame_seq_out_reg.sv
// rtl/crc_frame_seq_out_reg.sv - single-byte output slot (data + last) with valid/ready hold
module crc_seq_out_reg
  import crc_frame_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic [BYTE_W-1:0] data,
  output logic              valid,
  output logic              last,
  output logic              slot_free
);

  assign slot_free = !valid || ready;

  // Loads are only issued when slot_free, so a stalled byte is never overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/crc_frame_seq.sv
// rtl/crc_frame_seq.sv - frame sequencer feeding a CRC-16 stage and appending its two CRC bytes
// Optional build macro CRC_FRAME_SEQ_STATS_EN adds frame_cnt/trunc_cnt outputs.
module crc_frame_seq
  import crc_frame_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic clk,
  input  logic reset,
  crc_frame_seq_if.slave bus,
  output logic err_trunc,
  output logic busy
`ifdef CRC_FRAME_SEQ_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] trunc_cnt
`endif
);

  state_t            state;
  logic [LEN_W-1:0]  count;
  logic              trunc;
  logic              slot_free;
  logic              in_accept;
  logic              load;
  logic              load_last;
  logic [BYTE_W-1:0] load_data;

  assign bus.in_ready    = ((state == DATA) && slot_free) || (state == DROP);
  assign in_accept       = bus.in_valid && bus.in_ready;
  assign bus.crc_d       = bus.in_data;
  assign bus.crc_init    = (state == INIT);
  assign bus.crc_calc    = (state == DATA);
  assign bus.crc_d_valid = ((state == DATA) && in_accept) || ((state == CRC_HI) && slot_free);
  assign busy            = (state != IDLE);

  always_comb begin
    load      = 1'b0;
    load_data = bus.in_data;
    load_last = 1'b0;
    case (state)
      DATA:   load = in_accept;
      CRC_HI: begin
        load      = slot_free;
        load_data = bus.crc_byte;
      end
      CRC_LO: begin
        load      = slot_free;
        load_data = bus.crc_byte;
        load_last = 1'b1;
      end
      default: load = 1'b0;
    endcase
  end

  crc_seq_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .ready     (bus.out_ready),
    .data      (bus.out_data),
    .valid     (bus.out_valid),
    .last      (bus.out_last),
    .slot_free (slot_free)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      trunc     <= 1'b0;
      err_trunc <= 1'b0;
    end else begin
      err_trunc <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) state <= INIT;
        INIT: begin
          count <= '0;
          state <= DATA;
        end
        DATA: if (in_accept) begin
          count <= count + 1'b1;
          // in_last on the MAX_LEN-th byte is a normal end, not a truncation
          if (bus.in_last) begin
            state <= CRC_HI;
          end else if (count == LEN_W'(MAX_LEN - 1)) begin
            trunc <= 1'b1;
            state <= CRC_HI;
          end
        end
        CRC_HI: if (slot_free) state <= CRC_LO;
        CRC_LO: if (slot_free) begin
          err_trunc <= trunc;
          state     <= trunc ? DROP : IDLE;
        end
        DROP: if (bus.in_valid && bus.in_last) begin
          trunc <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRC_FRAME_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      if (bus.out_valid && bus.out_last && bus.out_ready) frame_cnt <= frame_cnt + 16'd1;
      if (err_trunc) trunc_cnt <= trunc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc_frame_seq.sv
// tb/tb_crc_frame_seq.sv - directed self-checking bench for crc_frame_seq with a stub CRC stage
module tb_crc_frame_seq;
  import crc_frame_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_trunc, busy;
`ifdef CRC_FRAME_SEQ_STATS_EN
  logic [15:0] frame_cnt, trunc_cnt;
`endif

  always #5 clk = ~clk;

  crc_frame_seq_if bus ();

  crc_frame_seq #(.MAX_LEN(4), .LEN_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_trunc (err_trunc),
    .busy      (busy)
`ifdef CRC_FRAME_SEQ_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .trunc_cnt (trunc_cnt)
`endif
  );

  // Stub CRC stage: high byte A5 after init, low byte 3C once shifted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.crc_byte <= 8'h00;
    else if (bus.crc_init) bus.crc_byte <= 8'hA5;
    else if (bus.crc_d_valid && !bus.crc_calc) bus.crc_byte <= 8'h3C;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int init_cnt, dv_cnt, n_err, n_err_last, stall_viol, init_cyc, last_cyc, init_gap, n_last;
  logic [7:0] crc_xor;
  logic [7:0] out_q[$];
  logic       last_q[$];
  logic       prev_hold;
  logic [7:0] prev_data;
  bit         stall_mode = 0;
  logic [7:0] fr [0:7];
  logic [7:0] exp_d [0:7];
  logic       exp_l [0:7];

  always @(posedge clk) begin
    #1;
    bus.out_ready = stall_mode ? ((cyc % 3) == 0) : 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && bus.out_valid && bus.out_data !== prev_data) stall_viol++;
      if (bus.crc_init) begin
        init_cnt++;
        init_gap = cyc - last_cyc;
        init_cyc = cyc;
      end
      if (bus.crc_d_valid) dv_cnt++;
      if (bus.crc_d_valid && bus.crc_calc) crc_xor = crc_xor ^ bus.crc_d;
      if (err_trunc) begin
        n_err++;
        if (bus.out_valid && bus.out_last) n_err_last++;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        if (bus.out_last) begin
          last_cyc = cyc;
          n_last++;
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    last_q.delete();
    init_cnt = 0; dv_cnt = 0; n_err = 0; n_err_last = 0; stall_viol = 0;
    init_cyc = 0; last_cyc = 0; init_gap = 0; n_last = 0; crc_xor = 8'h00;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last, output bit ok);
    int t = 0;
    bus.in_data  = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (bus.in_ready === 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, output bit ok);
    bit b;
    ok = 1;
    for (int i = 0; i < n; i++) begin
      drive_byte(fr[i], (i == n - 1), b);
      ok &= b;
    end
  endtask

  task automatic wait_out(input int n, output bit ok);
    int t = 0;
    while (!(out_q.size() >= n && !busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    ok = (out_q.size() == n) && !busy;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_last = 0; bus.in_data = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, err_trunc, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {bus.out_valid, bus.out_last, err_trunc, busy});
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_data got %h want 00", bus.out_data);
    end
    checks++;
    if ({bus.crc_init, bus.crc_calc, bus.crc_d_valid, bus.in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_crc got %b want 0000", {bus.crc_init, bus.crc_calc, bus.crc_d_valid, bus.in_ready});
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic(input string tag, input bit stall);
    bit ok, okw;
    fr[0] = 8'h31; fr[1] = 8'h32; fr[2] = 8'h33;
    exp_d[0] = 8'h31; exp_d[1] = 8'h32; exp_d[2] = 8'h33; exp_d[3] = 8'hA5; exp_d[4] = 8'h3C;
    for (int i = 0; i < 5; i++) exp_l[i] = (i == 4);
    clear_mon();
    stall_mode = stall;
    send_frame(3, ok);
    wait_out(3 + CRC_BYTES, okw);
    stall_mode = 0;
    checks++;
    if (!(ok && okw)) begin
      errors++;
      $display("FAIL %s_done got accept=%0d outs=%0d want 1 and 5", tag, ok, out_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d = (i < out_q.size()) ? out_q[i] : 8'hxx;
      logic       l = (i < last_q.size()) ? last_q[i] : 1'bx;
      checks++;
      if (d !== exp_d[i] || l !== exp_l[i]) begin
        errors++;
        $display("FAIL %s_byte%0d got %h/%b want %h/%b", tag, i, d, l, exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (init_cnt !== 1 || dv_cnt !== 4) begin
      errors++;
      $display("FAIL %s_crc_ctl got init=%0d dv=%0d want 1 4", tag, init_cnt, dv_cnt);
    end
    checks++;
    if (crc_xor !== 8'h30) begin
      errors++;
      $display("FAIL %s_crc_d got xor %h want 30", tag, crc_xor);
    end
    if (stall) begin
      checks++;
      if (stall_viol !== 0) begin
        errors++;
        $display("FAIL %s_stable got %0d changes want 0", tag, stall_viol);
      end
    end else begin
      checks++;
      if (last_cyc - init_cyc !== 6) begin
        errors++;
        $display("FAIL %s_latency got %0d want 6", tag, last_cyc - init_cyc);
      end
    end
  endtask

  task automatic test_trunc();
    bit ok, okw;
    for (int i = 0; i < 6; i++) fr[i] = 8'h10 + 8'(i);
    exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12; exp_d[3] = 8'h13;
    exp_d[4] = 8'hA5; exp_d[5] = 8'h3C;
    for (int i = 0; i < 6; i++) exp_l[i] = (i == 5);
    clear_mon();
    send_frame(6, ok);
    wait_out(4 + CRC_BYTES, okw);
    checks++;
    if (!(ok && okw)) begin
      errors++;
      $display("FAIL trunc_done got accept=%0d outs=%0d busy=%b want 1 6 0", ok, out_q.size(), busy);
    end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d = (i < out_q.size()) ? out_q[i] : 8'hxx;
      logic       l = (i < last_q.size()) ? last_q[i] : 1'bx;
      checks++;
      if (d !== exp_d[i] || l !== exp_l[i]) begin
        errors++;
        $display("FAIL trunc_byte%0d got %h/%b want %h/%b", i, d, l, exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (n_err !== 1 || n_err_last !== 1) begin
      errors++;
      $display("FAIL trunc_err got pulses=%0d with_last=%0d want 1 1", n_err, n_err_last);
    end
    checks++;
    if (dv_cnt !== 5) begin
      errors++;
      $display("FAIL trunc_dv got %0d want 5", dv_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, okw;
    clear_mon();
    fr[0] = 8'h00;
    send_frame(1, ok1);
    fr[0] = 8'h41; fr[1] = 8'h42; fr[2] = 8'h43;
    send_frame(3, ok2);
    wait_out(1 + 3 + 2 * CRC_BYTES, okw);
    exp_d[0] = 8'h00; exp_d[1] = 8'hA5; exp_d[2] = 8'h3C; exp_d[3] = 8'h41;
    exp_d[4] = 8'h42; exp_d[5] = 8'h43; exp_d[6] = 8'hA5; exp_d[7] = 8'h3C;
    for (int i = 0; i < 8; i++) exp_l[i] = (i == 2 || i == 7);
    checks++;
    if (!(ok1 && ok2 && okw)) begin
      errors++;
      $display("FAIL b2b_done got %0d%0d%0d outs=%0d want 111 8", ok1, ok2, okw, out_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d = (i < out_q.size()) ? out_q[i] : 8'hxx;
      logic       l = (i < last_q.size()) ? last_q[i] : 1'bx;
      checks++;
      if (d !== exp_d[i] || l !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d got %h/%b want %h/%b", i, d, l, exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (init_cnt !== 2 || init_gap !== 1) begin
      errors++;
      $display("FAIL b2b_init got count=%0d gap=%0d want 2 1", init_cnt, init_gap);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    drive_byte(8'h51, 1'b0, ok);
    bus.in_data = 8'h52; bus.in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_last, busy, bus.in_ready, bus.crc_init, bus.crc_calc, bus.crc_d_valid} !== 7'b0
        || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outs got v%b l%b b%b r%b crc%b%b%b d%h want all 0",
               bus.out_valid, bus.out_last, busy, bus.in_ready, bus.crc_init, bus.crc_calc,
               bus.crc_d_valid, bus.out_data);
    end
    checks++;
    if (n_last !== 0) begin
      errors++;
      $display("FAIL midreset_last got %0d want 0", n_last);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_basic("after_reset", 0);
  endtask

`ifdef CRC_FRAME_SEQ_STATS_EN
  task automatic test_stats();
    bit ok, okw;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    clear_mon();
    fr[0] = 8'h01; fr[1] = 8'h02;
    send_frame(2, ok); wait_out(4, okw);
    for (int i = 0; i < 5; i++) fr[i] = 8'h20 + 8'(i);
    send_frame(5, ok); wait_out(10, okw);
    fr[0] = 8'h77;
    send_frame(1, ok); wait_out(13, okw);
    checks++;
    if (frame_cnt !== 16'd3 || trunc_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stats got frames=%0d truncs=%0d want 3 1", frame_cnt, trunc_cnt);
    end
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_basic("basic", 0);
    test_basic("stall", 1);
    test_trunc();
    test_back_to_back();
    test_reset_mid();
`ifdef CRC_FRAME_SEQ_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
